// File: rtl/midi_pkg.sv
// Shared state type, frame constants and byte helper for the MIDI transmitter.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } midi_state_e;

  localparam int   FRAME_BITS        = 10;
  localparam int   NUM_DATA_BITS     = 8;
  localparam logic START_LEVEL       = 1'b0;
  localparam logic STOP_LEVEL        = 1'b1;
  localparam int   DEFAULT_BIT_TICKS = 128;

  // MIDI data bytes are 7-bit; the top bit on the wire is always 0.
  function automatic logic [7:0] data7(input logic [7:0] b);
    return b & 8'h7F;
  endfunction

endpackage

// File: rtl/midi_bit_timer.sv
// Bit-period timer: counts 0..TICKS-1 while enabled and strobes wrap on the last tick.
module midi_bit_timer #(
  parameter int TICKS = 128
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic wrap
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [W-1:0] cnt_q;

  assign wrap = en && (cnt_q == W'(TICKS - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      cnt_q <= '0;
    else if (!en)    cnt_q <= '0;
    else if (wrap)   cnt_q <= '0;
    else             cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/midi_transmitter.sv
// MIDI serial transmitter: sends STATUS/NOTE/VELOCITY as 8N1 frames, BIT_TICKS clocks per bit.
// Define MIDI_RUNNING_STATUS_EN to omit a status byte that repeats the previous message's.
//
// state     | meaning
// IDLE      | line high, waiting for START
// START_BIT | driving the 0 start bit of the current byte
// DATA_BITS | shifting out 8 data bits, LSB first
// STOP_BIT  | driving the 1 stop bit; then next byte or back to IDLE
module midi_transmitter
  import midi_pkg::*;
#(
  parameter int BIT_TICKS = DEFAULT_BIT_TICKS,
  parameter int MSG_BYTES = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] STATUS,
  input  logic [7:0] NOTE,
  input  logic [7:0] VELOCITY,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int               IDX_W    = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

  midi_state_e      state_q, state_n;
  logic [7:0]       status_q, status_n;
  logic [7:0]       note_q, note_n;
  logic [7:0]       vel_q, vel_n;
  logic [7:0]       shift_q, shift_n;
  logic [7:0]       cur_byte;
  logic [2:0]       bit_cnt_q, bit_cnt_n;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             bit_wrap;
  logic             skip_status;

  midi_bit_timer #(.TICKS(BIT_TICKS)) u_bit_timer (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (BUSY),
    .wrap (bit_wrap)
  );

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q;

  assign skip_status = STATUS[7] && (STATUS == last_status_q);

  // Updated on the completion edge so a START in the DONE cycle already sees it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      last_status_q <= 8'h00;
    else if (done_n) last_status_q <= status_q;
  end
`else
  assign skip_status = 1'b0;
`endif

  always_comb begin
    case (byte_idx_q)
      IDX_W'(0): cur_byte = status_q;
      IDX_W'(1): cur_byte = note_q;
      default:   cur_byte = vel_q;
    endcase
  end

  always_comb begin
    state_n    = state_q;
    status_n   = status_q;
    note_n     = note_q;
    vel_n      = vel_q;
    shift_n    = shift_q;
    bit_cnt_n  = bit_cnt_q;
    byte_idx_n = byte_idx_q;
    tx_n       = tx_q;
    done_n     = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        status_n   = STATUS;
        note_n     = data7(NOTE);
        vel_n      = data7(VELOCITY);
        byte_idx_n = skip_status ? IDX_W'(1) : '0;
        bit_cnt_n  = '0;
        tx_n       = START_LEVEL;
        state_n    = START_BIT;
      end
      START_BIT: if (bit_wrap) begin
        tx_n      = cur_byte[0];
        shift_n   = cur_byte >> 1;
        bit_cnt_n = '0;
        state_n   = DATA_BITS;
      end
      DATA_BITS: if (bit_wrap) begin
        if (bit_cnt_q == 3'(NUM_DATA_BITS - 1)) begin
          tx_n    = STOP_LEVEL;
          state_n = STOP_BIT;
        end else begin
          tx_n      = shift_q[0];
          shift_n   = shift_q >> 1;
          bit_cnt_n = bit_cnt_q + 1'b1;
        end
      end
      STOP_BIT: if (bit_wrap) begin
        if (byte_idx_q == LAST_IDX) begin
          byte_idx_n = '0;
          done_n     = 1'b1;
          state_n    = IDLE;
        end else begin
          byte_idx_n = byte_idx_q + 1'b1;
          tx_n       = START_LEVEL;
          state_n    = START_BIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      status_q   <= 8'h00;
      note_q     <= 8'h00;
      vel_q      <= 8'h00;
      shift_q    <= 8'h00;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      tx_q       <= STOP_LEVEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      status_q   <= status_n;
      note_q     <= note_n;
      vel_q      <= vel_n;
      shift_q    <= shift_n;
      bit_cnt_q  <= bit_cnt_n;
      byte_idx_q <= byte_idx_n;
      tx_q       <= tx_n;
      done_q     <= done_n;
    end
  end

  assign TX   = tx_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;

endmodule

// File: tb/tb_midi_transmitter.sv
// Directed bench for midi_transmitter: frame bits, bit timing, BUSY/DONE, START handling, reset.
module tb_midi_transmitter;

  localparam int BT = 128;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] STATUS = 8'h00;
  logic [7:0] NOTE = 8'h00;
  logic [7:0] VELOCITY = 8'h00;
  logic       TX, BUSY, DONE;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] last_st = 8'h00;
  time        done_t = 0;
  time        t_prev = 0;
  int         nb_a, nb_b;

  midi_transmitter #(.BIT_TICKS(BT), .MSG_BYTES(3)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .STATUS  (STATUS),
    .NOTE    (NOTE),
    .VELOCITY(VELOCITY),
    .TX      (TX),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] n, input logic [7:0] v);
    @(negedge CLK);
    STATUS = s; NOTE = n; VELOCITY = v; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Entered at the first negedge after the accepting posedge; leaves at the DONE-cycle negedge.
  task automatic watch_msg(input string tag, input logic [7:0] s, input logic [7:0] n,
                           input logic [7:0] v, input bit poke, output int nb);
    logic [7:0] bytes [3];
    logic [9:0] frame;
    logic       e, bad, early_done;
    int         total, busy_cnt, bi;
    nb = 3;
    bytes[0] = s;
    bytes[1] = n & 8'h7F;
    bytes[2] = v & 8'h7F;
`ifdef MIDI_RUNNING_STATUS_EN
    if (s[7] && s == last_st) begin
      nb = 2;
      bytes[0] = bytes[1];
      bytes[1] = bytes[2];
    end
`endif
    total = nb * 10 * BT;
    busy_cnt = 0;
    bad = 1'b0;
    early_done = 1'b0;
    for (int j = 0; j < total; j++) begin
      bi = j / BT;
      frame = {1'b1, bytes[bi / 10], 1'b0};
      e = frame[bi % 10];
      if (j % BT == 0) bad = 1'b0;
      if (TX !== e) bad = 1'b1;
      if (BUSY === 1'b1) busy_cnt++;
      if (DONE !== 1'b0) early_done = 1'b1;
      if (j % BT == BT - 1)
        check($sformatf("%s bit%0d", tag, bi), 32'({bad, TX}), 32'({1'b0, e}));
      if (poke && j == 500) begin
        START = 1'b1; STATUS = 8'hAA; NOTE = 8'h11; VELOCITY = 8'h22;
      end
      if (poke && j == 501) START = 1'b0;
      @(negedge CLK);
    end
    check($sformatf("%s done/busy/tx", tag), 32'({DONE, BUSY, TX}), 32'b101);
    check($sformatf("%s busy cycles", tag), 32'(busy_cnt), 32'(total));
    check($sformatf("%s early done", tag), 32'(early_done), 32'd0);
    done_t = $time;
    last_st = s;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("reset outputs", 32'({TX, BUSY, DONE}), 32'b100);

    // START on the first posedge after release
    @(posedge CLK); #1 RESET = 1'b1;
    pulse_start(8'h90, 8'h3C, 8'h40);
    watch_msg("basic", 8'h90, 8'h3C, 8'h40, 1'b0, nb_a);

    // START mid-message with changed operands must be ignored
    pulse_start(8'h90, 8'h3C, 8'h40);
    watch_msg("ignored start", 8'h90, 8'h3C, 8'h40, 1'b1, nb_a);
    @(negedge CLK);
    check("idle after poke", 32'({BUSY, TX, DONE}), 32'b010);

    pulse_start(8'h90, 8'hFF, 8'hC5);
    watch_msg("bit7 forced", 8'h90, 8'hFF, 8'hC5, 1'b0, nb_a);

    // Asynchronous reset mid-frame
    pulse_start(8'hB0, 8'h07, 8'h64);
    repeat (1000) @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check("async reset", 32'({TX, BUSY, DONE}), 32'b100);
    last_st = 8'h00;
    @(negedge CLK);
    check("held reset", 32'({TX, BUSY, DONE}), 32'b100);
    @(posedge CLK); #1 RESET = 1'b1;
    pulse_start(8'h90, 8'h45, 8'h12);
    watch_msg("after reset", 8'h90, 8'h45, 8'h12, 1'b0, nb_a);

    // START held high: back-to-back with one idle-high cycle between messages
    @(negedge CLK);
    STATUS = 8'h91; NOTE = 8'h30; VELOCITY = 8'h50; START = 1'b1;
    @(negedge CLK);
    watch_msg("held 1", 8'h91, 8'h30, 8'h50, 1'b0, nb_a);
    t_prev = done_t;
    @(negedge CLK);
    watch_msg("held 2", 8'h91, 8'h30, 8'h50, 1'b0, nb_b);
    START = 1'b0;
    check("done period", 32'((done_t - t_prev) / 10), 32'(1 + nb_b * 10 * BT));
    @(negedge CLK);
    check("idle after held", 32'({BUSY, TX, DONE}), 32'b010);

    // Running-status sequence from a clean reset: 0x90, 0x90 in the DONE cycle, then 0x80
    RESET = 1'b0;
    last_st = 8'h00;
    @(posedge CLK); #1 RESET = 1'b1;
    pulse_start(8'h90, 8'h40, 8'h7F);
    watch_msg("rs first", 8'h90, 8'h40, 8'h7F, 1'b0, nb_a);
    check("rs first bytes", 32'(nb_a), 32'd3);
    STATUS = 8'h90; NOTE = 8'h41; VELOCITY = 8'h20; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    watch_msg("rs repeat", 8'h90, 8'h41, 8'h20, 1'b0, nb_a);
`ifdef MIDI_RUNNING_STATUS_EN
    check("rs repeat bytes", 32'(nb_a), 32'd2);
`else
    check("rs repeat bytes", 32'(nb_a), 32'd3);
`endif
    pulse_start(8'h80, 8'h41, 8'h00);
    watch_msg("rs new status", 8'h80, 8'h41, 8'h00, 1'b0, nb_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
